pc_redirect_unit: RTL and testbench

Fetch-side PC generator and redirect controller sitting directly downstream of the branch-condition stage. It consumes the registered `br_taken` decision and its target, loads the new PC, and squashes wrong-path instructions with a multi-cycle flush. If the pipeline is stalled when a redirect arrives, it parks the redirect until the stall clears.

---
 rtl/pc_redirect_unit.sv | 119 +++++++++++
 tb/tb_pc_redirect_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with taken-branch redirect, stall parking and a multi-cycle flush.
// Optional `REDIRECT_STATS_EN adds a saturating redirect_count output.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misaligned
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count
`endif
);

  localparam int             CW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc_nxt;
  logic [31:0]   pend_target, pend_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mis_nxt;
  logic          tgt_aligned;

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign tgt_aligned = (br_target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      cnt         <= '0;
      pend_target <= '0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      cnt         <= cnt_nxt;
      pend_target <= pend_nxt;
      misaligned  <= mis_nxt;
    end
  end

  // Younger br_taken seen in PEND/FLUSH is wrong-path and is deliberately ignored.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    pend_nxt  = pend_target;
    mis_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (br_taken && !tgt_aligned)
          mis_nxt = 1'b1;
        if (br_taken && tgt_aligned) begin
          if (stall) begin
            pend_nxt  = br_target;
            state_nxt = PEND;
          end else begin
            pc_nxt    = br_target;
            cnt_nxt   = CNT_INIT;
            state_nxt = FLUSH;
          end
        end else if (!stall) begin
          pc_nxt = pc_inc(pc);
        end
      end
      PEND: begin
        if (!stall) begin
          pc_nxt    = pend_target;
          cnt_nxt   = CNT_INIT;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall) begin
          pc_nxt = pc_inc(pc);
          if (cnt == '0)
            state_nxt = RUN;
          else
            cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush            = (state == FLUSH) || (state == PEND);
  assign redirect_pending = (state == PEND);
  assign pc_valid         = reset && !stall && (state != PEND);

`ifdef REDIRECT_STATS_EN
  logic load_tgt;

  assign load_tgt = !stall &&
                    (((state == RUN) && br_taken && tgt_aligned) || (state == PEND));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      redirect_count <= '0;
    else if (load_tgt && (redirect_count != 32'hFFFF_FFFF))
      redirect_count <= redirect_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: driver pushes model expectations, monitor compares at negedge.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] pc;
  logic        pc_valid, flush, redirect_pending, misaligned;
`ifdef REDIRECT_STATS_EN
  logic [31:0] redirect_count;
`endif

  pc_redirect_unit #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .pc               (pc),
    .pc_valid         (pc_valid),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .misaligned       (misaligned)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_count   (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic        pcv;
    logic        mis;
    logic [31:0] rcnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a parked flag, a count of flush cycles still owed, and the PC.
  logic [31:0] m_pc;
  logic        m_parked;
  logic [31:0] m_parked_tgt;
  int          m_flush_left;
  logic        m_mis;
  logic [31:0] m_rcnt;

  task automatic model_reset();
    m_pc         = RESET_PC;
    m_parked     = 1'b0;
    m_parked_tgt = '0;
    m_flush_left = 0;
    m_mis        = 1'b0;
    m_rcnt       = '0;
  endtask

  task automatic count_redirect();
    if (m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
    logic nxt_mis;
    nxt_mis = 1'b0;
    if (m_parked) begin
      if (!s) begin
        m_pc = m_parked_tgt;
        m_parked = 1'b0;
        m_flush_left = FLUSH_CYCLES;
        count_redirect();
      end
    end else if (m_flush_left > 0) begin
      if (!s) begin
        m_pc = m_pc + 4;
        m_flush_left--;
      end
    end else begin
      if (b && (t % 4 != 0)) nxt_mis = 1'b1;
      if (b && (t % 4 == 0)) begin
        if (s) begin
          m_parked = 1'b1;
          m_parked_tgt = t;
        end else begin
          m_pc = t;
          m_flush_left = FLUSH_CYCLES;
          count_redirect();
        end
      end else if (!s) begin
        m_pc = m_pc + 4;
      end
    end
    m_mis = nxt_mis;
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; br_taken = b; br_target = t;
    if (!r) model_reset();
    e.pc    = m_pc;
    e.flush = m_parked || (m_flush_left > 0);
    e.pend  = m_parked;
    e.pcv   = r && !s && !m_parked;
    e.mis   = m_mis;
    e.rcnt  = m_rcnt;
    sb.push_back(e);
    if (r) model_edge(s, b, t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("pc", pc, e.pc);
        chk("flush", {31'd0, flush}, {31'd0, e.flush});
        chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.pcv});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
`ifdef REDIRECT_STATS_EN
        chk("redirect_count", redirect_count, e.rcnt);
`endif
      end
    end
  end

  initial begin : driver
    logic [31:0] tgt;
    logic        s, b;
    model_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reset release, sequential fetch
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    // Unstalled redirect and its flush window
    step(1, 0, 1, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    // Stalled redirect with a younger branch arriving during the stall
    step(1, 1, 1, 32'h0000_0200);
    step(1, 1, 1, 32'h0000_0300);
    step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    // Misaligned target is dropped
    step(1, 0, 1, 32'h0000_0102);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // Branch in flush is ignored, stall inside flush freezes the count
    step(1, 0, 1, 32'h0000_0400);
    step(1, 1, 1, 32'h0000_0503);
    step(1, 0, 1, 32'h0000_0600);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // Wrap at top of address space
    step(1, 0, 1, 32'hFFFF_FFF0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    // Reset asserted in the first flush cycle
    step(1, 0, 1, 32'h0000_0800);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // Reset asserted while a redirect is parked
    step(1, 1, 1, 32'h0000_0900);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      s = ($urandom_range(9) < 3);
      b = ($urandom_range(9) < 2);
      if ($urandom_range(199) == 0) step(0, s, 0, 0);
      else step(1, s, b, tgt);
    end
    step(1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
